alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single combinational Embertrail ALU between two requesters, for example the instruction datapath and the address/loop unit. It arbitrates round-robin, registers the winner's operands and operation onto the ALU inputs, captures the ALU result one cycle later, and returns it with a one-cycle done pulse. It sits between the requesters and the ALU and owns all ALU input drive.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must match the ALU.
- OPW, 8, one-hot operation code width; must match the ALU.

Ports:
- iClock  in  1  single clock; all state updates on the rising edge.
- iReset  in  1  synchronous, active-high reset.
- iReq0, iReq1  in  1  request from requester 0 / 1.
- iOpA0, iOpA1  in  WIDTH  operand A per requester.
- iOpB0, iOpB1  in  WIDTH  operand B per requester.
- iOp0, iOp1  in  OPW  one-hot ALU op per requester (0x01 ADD, 0x02 AND, 0x04 OR, 0x08 NOT, 0x10 XOR, 0x20 SL, 0x40 SR, 0x80 CMP).
- oDone0, oDone1  out  1  one-cycle pulse; oResult is valid for that requester.
- oResult  out  WIDTH  registered ALU result; holds its value until the next capture.
- oBusy  out  1  high in ISSUE and DONE.
- oAluOperandA, oAluOperandB  out  WIDTH  registered drive to ALU operands.
- oAluOperation  out  OPW  registered drive to ALU op; 0 whenever not in ISSUE.
- iAluResult  in  WIDTH  combinational ALU result.

## Operation
- FSM states: IDLE, ISSUE, DONE. Reset state is IDLE.
- Arbitration runs in IDLE and DONE over the eligible requests:
  - Exactly one eligible request: grant it.
  - Both eligible: grant the requester not served last.
  - lastGrant reset value is 1, so requester 0 wins the first tie.
- On a grant:
  - Latch the winner's iOpA/iOpB/iOp into the ALU drive registers.
  - Latch the winner's index and update lastGrant.
  - Go to ISSUE.
- With no grant: IDLE stays in IDLE; DONE goes to IDLE.
- ISSUE (exactly 1 cycle):
  - ALU inputs are stable from the registers.
  - At the clock edge, iAluResult is captured into oResult.
  - Go to DONE.
- DONE (1 cycle):
  - Assert oDone for the served index.
  - The served requester is masked from arbitration this cycle.
  - The other requester may be granted, which gives back-to-back ISSUE.
- Operations are passed through unchecked. A non-one-hot code reaches the ALU, which returns 0, and completes normally.
- Handshake rules:
  - A requester holds iReq high until its grant is latched. Operands are sampled only at the grant edge and may change afterwards.
  - A requester deasserts iReq in the cycle after its oDone unless it has a new request. iReq high in that cycle is a new request.
- Registers in the idle path:
  - oAluOperation returns to 0 on leaving ISSUE.
  - oAluOperandA/B keep their last values.

## Timing
- Reset: state=IDLE, oDone0/1=0, oBusy=0, oResult=0, oAluOperandA/B=0, oAluOperation=0, lastGrant=1.
- iReset high mid-operation aborts the operation: no oDone is issued and the in-flight result is discarded.
- Latency: iReq sampled high at edge N (state IDLE) gives:
  - ISSUE during cycle N+1.
  - oDone and oResult valid during cycle N+2.
- Throughput:
  - Alternating requesters: one result every 2 cycles.
  - A single requester alone: one result every 3 cycles, because it is masked in DONE.
- Simultaneous requests in the same cycle: resolved by round-robin only. Neither request is lost; the loser keeps iReq high and is granted at the next arbitration point (the DONE state).
- oDone0 and oDone1 are never high in the same cycle.

## Test plan
- Single add: reset, then iReq0=1, iOpA0=0x0003, iOpB0=0x0004, iOp0=0x01.
  - Expect oAluOperation=0x01 one cycle later.
  - Expect oDone0=1 and oResult=0x0007 two cycles later; oDone1 stays 0.
- Tie and round-robin: both request from reset, op0 = XOR 0x00FF^0x0F0F, op1 = SL 0x0001<<4.
  - Expect oDone0 first with 0x0FF0.
  - Expect oDone1 exactly 2 cycles later with 0x0010.
  - Repeat the tie: requester 0 wins again, since lastGrant=1.
- Repeated requests from one requester: iReq1 held high for 3 CMP ops (0x1234 vs 0x1234).
  - Expect oDone1 every 3 cycles with oResult=0x0001.
  - Expect oAluOperation=0 in non-ISSUE cycles.
- Illegal op: iOp0=0x03 with A=0x5555, B=0xAAAA.
  - Expect normal completion with oResult=0x0000.
- Reset mid-op: assert iReset during ISSUE.
  - Expect no oDone and all outputs at their reset values the next cycle.
  - Expect the next request to complete with normal latency.
- Operand change after grant: change iOpA0 in the ISSUE cycle.
  - Expect the result to use the value latched at grant.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Requester-side and ALU-side signal bundle for alu_arbiter.
// The slave modport is the arbiter's view; master is the requesters/ALU side.
interface alu_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int OPW   = 8
);
  logic             iReq0;
  logic             iReq1;
  logic [WIDTH-1:0] iOpA0;
  logic [WIDTH-1:0] iOpA1;
  logic [WIDTH-1:0] iOpB0;
  logic [WIDTH-1:0] iOpB1;
  logic [OPW-1:0]   iOp0;
  logic [OPW-1:0]   iOp1;
  logic             oDone0;
  logic             oDone1;
  logic [WIDTH-1:0] oResult;
  logic             oBusy;
  logic [WIDTH-1:0] oAluOperandA;
  logic [WIDTH-1:0] oAluOperandB;
  logic [OPW-1:0]   oAluOperation;
  logic [WIDTH-1:0] iAluResult;

  modport slave (
    input  iReq0, iReq1, iOpA0, iOpA1, iOpB0, iOpB1, iOp0, iOp1, iAluResult,
    output oDone0, oDone1, oResult, oBusy, oAluOperandA, oAluOperandB, oAluOperation
  );

  modport master (
    output iReq0, iReq1, iOpA0, iOpA1, iOpB0, iOpB1, iOp0, iOp1, iAluResult,
    input  oDone0, oDone1, oResult, oBusy, oAluOperandA, oAluOperandB, oAluOperation
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters:
// grant -> ISSUE (ALU inputs registered) -> DONE (result + one-cycle done pulse).
module alu_arbiter #(
  parameter int WIDTH = 16,
  parameter int OPW   = 8
) (
  input logic           iClock,
  input logic           iReset,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_r;
  logic             last_grant_r;
  logic             served_r;

  logic             elig0_s;
  logic             elig1_s;
  logic             grant_vld_s;
  logic             grant_idx_s;
  logic [WIDTH-1:0] grant_a_s;
  logic [WIDTH-1:0] grant_b_s;
  logic [OPW-1:0]   grant_op_s;

  // Arbitration: the requester just served is masked while its done pulse is out.
  always_comb begin
    elig0_s     = bus.iReq0 & ~((state_r == DONE) & (served_r == 1'b0));
    elig1_s     = bus.iReq1 & ~((state_r == DONE) & (served_r == 1'b1));
    grant_vld_s = elig0_s | elig1_s;
    if (elig0_s && elig1_s) begin
      grant_idx_s = ~last_grant_r;
    end else if (elig0_s) begin
      grant_idx_s = 1'b0;
    end else if (elig1_s) begin
      grant_idx_s = 1'b1;
    end else begin
      grant_idx_s = last_grant_r;
    end
    if (grant_idx_s) begin
      grant_a_s  = bus.iOpA1;
      grant_b_s  = bus.iOpB1;
      grant_op_s = bus.iOp1;
    end else begin
      grant_a_s  = bus.iOpA0;
      grant_b_s  = bus.iOpB0;
      grant_op_s = bus.iOp0;
    end
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_r           <= IDLE;
      last_grant_r      <= 1'b1;
      served_r          <= 1'b0;
      bus.oDone0        <= 1'b0;
      bus.oDone1        <= 1'b0;
      bus.oBusy         <= 1'b0;
      bus.oResult       <= {WIDTH{1'b0}};
      bus.oAluOperandA  <= {WIDTH{1'b0}};
      bus.oAluOperandB  <= {WIDTH{1'b0}};
      bus.oAluOperation <= {OPW{1'b0}};
    end else begin
      bus.oDone0 <= 1'b0;
      bus.oDone1 <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          if (grant_vld_s) begin
            bus.oAluOperandA  <= grant_a_s;
            bus.oAluOperandB  <= grant_b_s;
            bus.oAluOperation <= grant_op_s;
            served_r          <= grant_idx_s;
            last_grant_r      <= grant_idx_s;
            bus.oBusy         <= 1'b1;
            state_r           <= ISSUE;
          end else begin
            bus.oAluOperation <= {OPW{1'b0}};
            bus.oBusy         <= 1'b0;
            state_r           <= IDLE;
          end
        end
        ISSUE: begin
          bus.oResult       <= bus.iAluResult;
          bus.oAluOperation <= {OPW{1'b0}};
          bus.oDone0        <= ~served_r;
          bus.oDone1        <= served_r;
          bus.oBusy         <= 1'b1;
          state_r           <= DONE;
        end
        default: begin
          bus.oAluOperation <= {OPW{1'b0}};
          bus.oBusy         <= 1'b0;
          state_r           <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural ALU on the ALU side.
module tb_alu_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  alu_arbiter_if #(.WIDTH(16), .OPW(8)) bus ();

  alu_arbiter #(.WIDTH(16), .OPW(8)) dut (
    .iClock (clk),
    .iReset (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [7:0] op);
    case (op)
      8'h01:   alu_model = a + b;
      8'h02:   alu_model = a & b;
      8'h04:   alu_model = a | b;
      8'h08:   alu_model = ~a;
      8'h10:   alu_model = a ^ b;
      8'h20:   alu_model = a << b[3:0];
      8'h40:   alu_model = a >> b[3:0];
      8'h80:   alu_model = (a == b) ? 16'd1 : 16'd0;
      default: alu_model = 16'd0;
    endcase
  endfunction

  always_comb bus.iAluResult = alu_model(bus.oAluOperandA, bus.oAluOperandB, bus.oAluOperation);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_done0"}, {31'd0, bus.oDone0}, 32'd0);
    check_eq({tag, "_done1"}, {31'd0, bus.oDone1}, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, bus.oBusy}, 32'd0);
    check_eq({tag, "_op"}, {24'd0, bus.oAluOperation}, 32'h0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.iReq0 = 1'b0;
    bus.iReq1 = 1'b0;
    bus.iOpA0 = 16'h0000;
    bus.iOpB0 = 16'h0000;
    bus.iOp0  = 8'h00;
    bus.iOpA1 = 16'h0000;
    bus.iOpB1 = 16'h0000;
    bus.iOp1  = 8'h00;

    // Reset values
    do_reset();
    check_idle_outputs("rst");
    check_eq("rst_result", {16'd0, bus.oResult}, 32'h0);
    check_eq("rst_opa", {16'd0, bus.oAluOperandA}, 32'h0);
    check_eq("rst_opb", {16'd0, bus.oAluOperandB}, 32'h0);

    // Single add 3 + 4
    bus.iReq0 = 1'b1; bus.iOpA0 = 16'h0003; bus.iOpB0 = 16'h0004; bus.iOp0 = 8'h01;
    tick();
    check_eq("add_issue_op", {24'd0, bus.oAluOperation}, 32'h01);
    check_eq("add_issue_busy", {31'd0, bus.oBusy}, 32'd1);
    check_eq("add_issue_done0", {31'd0, bus.oDone0}, 32'd0);
    bus.iReq0 = 1'b0;
    tick();
    check_eq("add_done0", {31'd0, bus.oDone0}, 32'd1);
    check_eq("add_done1", {31'd0, bus.oDone1}, 32'd0);
    check_eq("add_result", {16'd0, bus.oResult}, 32'h0007);
    check_eq("add_done_op", {24'd0, bus.oAluOperation}, 32'h0);
    check_eq("add_done_busy", {31'd0, bus.oBusy}, 32'd1);
    tick();
    check_idle_outputs("add_idle");
    check_eq("add_hold_result", {16'd0, bus.oResult}, 32'h0007);
    check_eq("add_hold_opa", {16'd0, bus.oAluOperandA}, 32'h0003);

    // Tie from reset: requester 0 first, requester 1 two cycles later
    do_reset();
    bus.iReq0 = 1'b1; bus.iOpA0 = 16'h00FF; bus.iOpB0 = 16'h0F0F; bus.iOp0 = 8'h10;
    bus.iReq1 = 1'b1; bus.iOpA1 = 16'h0001; bus.iOpB1 = 16'h0004; bus.iOp1 = 8'h20;
    for (int r = 0; r < 2; r++) begin
      tick();
      check_eq("tie_issue0_op", {24'd0, bus.oAluOperation}, 32'h10);
      bus.iReq0 = 1'b0;
      tick();
      check_eq("tie_done0", {31'd0, bus.oDone0}, 32'd1);
      check_eq("tie_done0_other", {31'd0, bus.oDone1}, 32'd0);
      check_eq("tie_result0", {16'd0, bus.oResult}, 32'h0FF0);
      tick();
      check_eq("tie_issue1_op", {24'd0, bus.oAluOperation}, 32'h20);
      check_eq("tie_issue1_done0", {31'd0, bus.oDone0}, 32'd0);
      bus.iReq1 = 1'b0;
      tick();
      check_eq("tie_done1", {31'd0, bus.oDone1}, 32'd1);
      check_eq("tie_done1_other", {31'd0, bus.oDone0}, 32'd0);
      check_eq("tie_result1", {16'd0, bus.oResult}, 32'h0010);
      tick();
      check_idle_outputs("tie_idle");
      bus.iReq0 = 1'b1;
      bus.iReq1 = 1'b1;
    end
    bus.iReq0 = 1'b0;
    bus.iReq1 = 1'b0;

    // Requester 1 alone, three CMP ops: one result every 3 cycles
    bus.iReq1 = 1'b1; bus.iOpA1 = 16'h1234; bus.iOpB1 = 16'h1234; bus.iOp1 = 8'h80;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("cmp_issue_op", {24'd0, bus.oAluOperation}, 32'h80);
      check_eq("cmp_issue_done1", {31'd0, bus.oDone1}, 32'd0);
      tick();
      check_eq("cmp_done1", {31'd0, bus.oDone1}, 32'd1);
      check_eq("cmp_result", {16'd0, bus.oResult}, 32'h0001);
      check_eq("cmp_done_op", {24'd0, bus.oAluOperation}, 32'h0);
      if (k == 2) bus.iReq1 = 1'b0;
      tick();
      check_idle_outputs("cmp_gap");
    end

    // Non-one-hot op completes with zero result
    bus.iReq0 = 1'b1; bus.iOpA0 = 16'h5555; bus.iOpB0 = 16'hAAAA; bus.iOp0 = 8'h03;
    tick();
    check_eq("ill_issue_op", {24'd0, bus.oAluOperation}, 32'h03);
    bus.iReq0 = 1'b0;
    tick();
    check_eq("ill_done0", {31'd0, bus.oDone0}, 32'd1);
    check_eq("ill_result", {16'd0, bus.oResult}, 32'h0000);
    tick();

    // Reset during ISSUE aborts the operation
    bus.iReq0 = 1'b1; bus.iOpA0 = 16'h0010; bus.iOpB0 = 16'h0020; bus.iOp0 = 8'h01;
    tick();
    check_eq("abort_issue_op", {24'd0, bus.oAluOperation}, 32'h01);
    bus.iReq0 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_outputs("abort");
    check_eq("abort_result", {16'd0, bus.oResult}, 32'h0);
    check_eq("abort_opa", {16'd0, bus.oAluOperandA}, 32'h0);
    tick();
    check_idle_outputs("abort_after");
    bus.iReq0 = 1'b1; bus.iOpA0 = 16'h0100; bus.iOpB0 = 16'h0011; bus.iOp0 = 8'h04;
    tick();
    check_eq("post_abort_op", {24'd0, bus.oAluOperation}, 32'h04);
    bus.iReq0 = 1'b0;
    tick();
    check_eq("post_abort_done0", {31'd0, bus.oDone0}, 32'd1);
    check_eq("post_abort_result", {16'd0, bus.oResult}, 32'h0111);
    tick();

    // Operand change after grant does not affect the result
    bus.iReq0 = 1'b1; bus.iOpA0 = 16'h0F00; bus.iOpB0 = 16'h00F0; bus.iOp0 = 8'h01;
    tick();
    bus.iReq0 = 1'b0;
    bus.iOpA0 = 16'hFFFF;
    #1;
    check_eq("latch_opa", {16'd0, bus.oAluOperandA}, 32'h0F00);
    tick();
    check_eq("latch_done0", {31'd0, bus.oDone0}, 32'd1);
    check_eq("latch_result", {16'd0, bus.oResult}, 32'h0FF0);
    tick();
    check_idle_outputs("final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
